// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - requester-side handshake bundle for the DRAM port arbiter.
interface dram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin fetch/data arbiter serialising word accesses to the DRAM array.
module dram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dram_port_arbiter_if.slave    ports,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  gnt_d;
  logic                  last_d;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  any_req;
  logic                  win_d;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  last_cycle;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    any_req  = ports.if_req | ports.d_req;
    win_d    = ports.d_req & (~ports.if_req | ~last_d);
    win_addr = win_d ? ports.d_addr : ports.if_addr;
  end

  always_comb begin
    state_nxt  = state;
    last_cycle = 1'b0;
    mem_wren   = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = BUSY;
      BUSY: begin
        if (cnt == 4'd0) begin
          last_cycle = 1'b1;
          state_nxt  = RESP;
          mem_wren   = we_q & ~err_q;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      gnt_d   <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d   <= win_d;
            last_d  <= win_d;
            we_q    <= win_d & ports.d_we;
            addr_q  <= win_addr;
            wdata_q <= win_d ? ports.d_wdata : '0;
            err_q   <= (win_addr[1:0] != 2'b00);
            cnt     <= CNT_INIT;
          end
        end
        BUSY: begin
          if (!last_cycle) cnt <= cnt - 4'd1;
          // Misaligned loads and all stores return zero read data.
          else rdata_q <= (we_q | err_q) ? '0 : mem_data;
        end
        default: ;
      endcase
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = mem_wren ? wdata_q : {DATA_WIDTH{1'bz}};
  assign busy        = (state != IDLE);

  assign ports.if_ack   = (state == RESP) & ~gnt_d;
  assign ports.d_ack    = (state == RESP) &  gnt_d;
  assign ports.if_rdata = ports.if_ack ? rdata_q : '0;
  assign ports.d_rdata  = ports.d_ack  ? rdata_q : '0;
  assign ports.if_err   = ports.if_ack & err_q;
  assign ports.d_err    = ports.d_ack  & err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard bench for dram_port_arbiter with a behavioural DRAM array.
module tb_dram_port_arbiter;

  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dram_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();
  dram_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus2 ();

  wire  [31:0] mem_data;
  wire  [31:0] mem2_data;
  logic [15:0] mem_address, mem2_address;
  logic        mem_wren, mem2_wren, busy, busy2;

  dram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .ports(bus1.slave),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .busy(busy)
  );

  dram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .ports(bus2.slave),
    .mem_address(mem2_address), .mem_wren(mem2_wren), .mem_data(mem2_data), .busy(busy2)
  );

  logic [31:0] mem [0:16383];
  assign mem_data = mem_wren ? 32'bz : mem[mem_address[15:2]];
  always @(posedge clock) if (mem_wren) mem[mem_address[15:2]] <= mem_data;

  assign mem2_data = mem2_wren ? 32'bz : {16'hA5A5, mem2_address};

  logic [31:0] model [int];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        port_d;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      if (!mem_wren) check_eq("bus_no_x", 64'($isunknown(mem_data)), 64'd0);
      if (bus1.if_ack || bus1.d_ack) begin
        check_eq("single_ack", 64'(bus1.if_ack & bus1.d_ack), 64'd0);
        check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("ack_port", 64'(bus1.d_ack), 64'(mon_e.port_d));
          check_eq("ack_err", 64'(mon_e.port_d ? bus1.d_err : bus1.if_err), 64'(mon_e.err));
          if (mon_e.chk_rd)
            check_eq("ack_rdata", 64'(mon_e.port_d ? bus1.d_rdata : bus1.if_rdata), 64'(mon_e.rdata));
        end
      end
    end
  end

  function automatic sb_t expect_of(input logic port_d, input logic we, input logic [15:0] addr);
    sb_t e;
    e.port_d = port_d;
    e.err    = (addr[1:0] != 2'b00);
    e.chk_rd = !we;
    e.rdata  = (e.err || we) ? 32'd0 : model[int'(addr[15:2])];
    return e;
  endfunction

  task automatic access(input logic port_d, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, output int ack_cyc, output int wren_n,
                        output int wren_at);
    int n;
    sb.push_back(expect_of(port_d, we, addr));
    if (port_d && we && addr[1:0] == 2'b00) model[int'(addr[15:2])] = wdata;
    wren_n = 0;
    wren_at = -1;
    @(negedge clock);
    if (port_d) begin
      bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
    end else begin
      bus1.if_req = 1'b1; bus1.if_addr = addr;
    end
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (mem_wren) begin wren_n++; wren_at = n; end
      if (port_d ? bus1.d_ack : bus1.if_ack) break;
    end
    ack_cyc = n;
    bus1.d_req = 1'b0;
    bus1.if_req = 1'b0;
  endtask

  task automatic tie(input logic [15:0] if_a, input logic [15:0] d_a, input logic if_first);
    int ack_if, ack_d;
    ack_if = 0;
    ack_d = 0;
    if (if_first) begin
      sb.push_back(expect_of(1'b0, 1'b0, if_a));
      sb.push_back(expect_of(1'b1, 1'b0, d_a));
    end else begin
      sb.push_back(expect_of(1'b1, 1'b0, d_a));
      sb.push_back(expect_of(1'b0, 1'b0, if_a));
    end
    @(negedge clock);
    bus1.if_req = 1'b1; bus1.if_addr = if_a;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = d_a;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (bus1.if_ack) begin ack_if = n; bus1.if_req = 1'b0; end
      if (bus1.d_ack) begin ack_d = n; bus1.d_req = 1'b0; end
      if (ack_if != 0 && ack_d != 0) break;
    end
    bus1.if_req = 1'b0;
    bus1.d_req = 1'b0;
    check_eq("tie_if_cycle", 64'(ack_if), 64'(if_first ? LAT + 1 : 2 * LAT + 3));
    check_eq("tie_d_cycle", 64'(ack_d), 64'(if_first ? 2 * LAT + 3 : LAT + 1));
  endtask

  int ack_c, wr_n, wr_at;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
    for (int i = 0; i < 64; i++) model[i] = init_word(i);
    mem[8] = 32'h12345678;
    model[8] = 32'h12345678;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
    bus2.if_req = 0; bus2.if_addr = 0; bus2.d_req = 0; bus2.d_we = 0;
    bus2.d_addr = 0; bus2.d_wdata = 0;

    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wren", 64'(mem_wren), 64'd0);
    check_eq("rst_addr", 64'(mem_address), 64'd0);
    check_eq("rst_acks", 64'({bus1.if_ack, bus1.d_ack, bus1.if_err, bus1.d_err}), 64'd0);
    check_eq("rst_rdata", 64'({bus1.if_rdata, bus1.d_rdata}), 64'd0);
    check_eq("rst_bus", 64'(mem_data), 64'(mem[0]));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // First tie after reset goes to the fetch port.
    tie(16'h0030, 16'h0020, 1'b1);

    access(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, ack_c, wr_n, wr_at);
    check_eq("st_ack_cycle", 64'(ack_c), 64'(LAT + 1));
    check_eq("st_wren_count", 64'(wr_n), 64'd1);
    check_eq("st_wren_cycle", 64'(wr_at), 64'(LAT));
    check_eq("st_array", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);

    access(1'b0, 1'b0, 16'h0010, 32'd0, ack_c, wr_n, wr_at);
    check_eq("ld_ack_cycle", 64'(ack_c), 64'(LAT + 1));
    check_eq("ld_wren_count", 64'(wr_n), 64'd0);

    // Fetch port was granted last, so this tie goes to data.
    tie(16'h0030, 16'h0020, 1'b0);

    access(1'b1, 1'b1, 16'h0013, 32'hFFFFFFFF, ack_c, wr_n, wr_at);
    check_eq("mis_st_ack", 64'(ack_c), 64'(LAT + 1));
    check_eq("mis_st_wren", 64'(wr_n), 64'd0);
    check_eq("mis_st_array", 64'(mem[4]), 64'h0000_0000_DEAD_BEEF);

    access(1'b0, 1'b0, 16'h0022, 32'd0, ack_c, wr_n, wr_at);
    check_eq("mis_ld_ack", 64'(ack_c), 64'(LAT + 1));

    // Abort a store in its second busy cycle.
    @(negedge clock);
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 16'h0040; bus1.d_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_wren", 64'(mem_wren), 64'd0);
    check_eq("abort_addr", 64'(mem_address), 64'd0);
    check_eq("abort_ack", 64'({bus1.if_ack, bus1.d_ack}), 64'd0);
    bus1.d_req = 1'b0;
    repeat (LAT + 2) @(negedge clock);
    check_eq("abort_array", 64'(mem[16]), 64'(init_word(16)));
    reset = 1'b1;

    access(1'b0, 1'b0, 16'h0040, 32'd0, ack_c, wr_n, wr_at);
    check_eq("post_rst_ack", 64'(ack_c), 64'(LAT + 1));

    // LATENCY=1 instance with a continuously held load request.
    @(negedge clock);
    bus2.d_req = 1'b1; bus2.d_addr = 16'h0100;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      check_eq("l1_ack", 64'(bus2.d_ack), 64'((n % 3) == 2));
      check_eq("l1_busy", 64'(busy2), 64'((n % 3) != 0));
      if (bus2.d_ack) check_eq("l1_rdata", 64'(bus2.d_rdata), 64'h0000_0000_A5A5_0100);
    end
    bus2.d_req = 1'b0;
    repeat (3) @(negedge clock);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
